// File: rtl/pipe_lane_scheduler_if.sv
// Spawn-request inputs and per-lane render outputs of pipe_lane_scheduler.
// master = game-state/renderer side, slave = the scheduler.
interface pipe_lane_scheduler_if #(
    parameter int unsigned NUM_LANES = 3
);
    logic                    spawnReq;
    logic [9:0]              pointY;
    logic [9:0]              score;
    logic [10*NUM_LANES-1:0] laneX;
    logic [10*NUM_LANES-1:0] downY;
    logic [10*NUM_LANES-1:0] upSkipY;
    logic [NUM_LANES-1:0]    downVisible;
    logic [NUM_LANES-1:0]    upVisible;
    logic [NUM_LANES-1:0]    laneEndPulse;
    logic                    endOfMapPipe;
    logic                    spawnDropped;
    logic [3:0]              activeCount;

    modport master (
        output spawnReq, pointY, score,
        input  laneX, downY, upSkipY, downVisible, upVisible, laneEndPulse,
               endOfMapPipe, spawnDropped, activeCount
    );

    modport slave (
        input  spawnReq, pointY, score,
        output laneX, downY, upSkipY, downVisible, upVisible, laneEndPulse,
               endOfMapPipe, spawnDropped, activeCount
    );
endinterface

// File: rtl/pipe_lane_scheduler.sv
// Multi-lane pipe animator: lowest-free-lane spawn allocation with cooldown,
// per-lane fixed-point leftward motion at a score-dependent speed, left-edge expiry.
module pipe_lane_scheduler #(
    parameter int unsigned NUM_LANES        = 3,
    parameter int unsigned SCALE            = 100,
    parameter int unsigned SPAWN_X          = 650,
    parameter int unsigned SPEED_PER_SCORE  = 35,
    parameter int unsigned MIN_SPEED        = 220,
    parameter int unsigned DOUBLE_MIN_SCORE = 10,
    parameter int unsigned BASE_GAP         = 175,
    parameter int unsigned MIN_GAP          = 150,
    parameter int unsigned GAP_STEP         = 20,
    parameter int unsigned UP_IMG           = 402,
    parameter int unsigned SCREEN_MID       = 240,
    parameter int unsigned SPAWN_COOLDOWN   = 40
) (
    input logic                  animationCLOCK,
    input logic                  reset,
    pipe_lane_scheduler_if.slave bus
);
    localparam logic [19:0] SPAWN_POS     = 20'(SPAWN_X * SCALE);
    localparam logic [15:0] COOLDOWN_LOAD = 16'(SPAWN_COOLDOWN);

    logic [NUM_LANES-1:0] en_q, en_d;
    logic [19:0]          pos_q    [NUM_LANES];
    logic [19:0]          pos_d    [NUM_LANES];
    logic [9:0]           y_q      [NUM_LANES];
    logic [9:0]           y_d      [NUM_LANES];
    logic [9:0]           scoreL_q [NUM_LANES];
    logic [9:0]           scoreL_d [NUM_LANES];
    logic [9:0]           gap_q    [NUM_LANES];
    logic [9:0]           gap_d    [NUM_LANES];
    logic [15:0]          cooldown_q, cooldown_d;
    logic                 reqPrev_q;
    logic [NUM_LANES-1:0] laneEnd_q, laneEnd_d;
    logic                 dropped_q, dropped_d;
    logic [3:0]           count_q, count_d;

    logic                 spawn_edge;
    logic                 free_found;
    int unsigned          free_idx;
    logic [19:0]          gap_r;
    logic [9:0]           gap_new;
    logic [19:0]          spd [NUM_LANES];

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            spd[i] = ({10'd0, scoreL_q[i]} + 20'd1) * 20'(SPEED_PER_SCORE) + 20'(MIN_SPEED);
        end
    end

    // gap_r wraps for scores below the threshold, but is only consulted above it
    always_comb begin
        gap_r   = ({10'd0, bus.score} - 20'(DOUBLE_MIN_SCORE)) * 20'(GAP_STEP);
        gap_new = '0;
        if (bus.score >= 10'(DOUBLE_MIN_SCORE)) begin
            if (gap_r > 20'(BASE_GAP - MIN_GAP)) begin
                gap_new = 10'(MIN_GAP);
            end else begin
                gap_new = 10'(20'(BASE_GAP) - gap_r);
            end
        end
    end

    // Free-lane search uses the registered enables, so a lane expiring this tick stays busy
    always_comb begin
        free_found = 1'b0;
        free_idx   = 0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!en_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = i;
            end
        end
    end

    always_comb begin
        spawn_edge = bus.spawnReq & ~reqPrev_q;
        en_d       = en_q;
        laneEnd_d  = '0;
        dropped_d  = 1'b0;
        cooldown_d = (cooldown_q != '0) ? cooldown_q - 16'd1 : '0;

        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            pos_d[i]    = pos_q[i];
            y_d[i]      = y_q[i];
            scoreL_d[i] = scoreL_q[i];
            gap_d[i]    = gap_q[i];
            if (en_q[i]) begin
                if (pos_q[i] < spd[i]) begin
                    en_d[i]      = 1'b0;
                    pos_d[i]     = '0;
                    laneEnd_d[i] = 1'b1;
                end else begin
                    pos_d[i] = pos_q[i] - spd[i];
                end
            end
        end

        if (spawn_edge) begin
            if (cooldown_q != '0 || !free_found) begin
                dropped_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    if (i == free_idx) begin
                        en_d[i]     = 1'b1;
                        pos_d[i]    = SPAWN_POS;
                        y_d[i]      = bus.pointY;
                        scoreL_d[i] = bus.score;
                        gap_d[i]    = gap_new;
                    end
                end
                cooldown_d = COOLDOWN_LOAD;
            end
        end

        count_d = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            count_d = count_d + {3'b000, en_d[i]};
        end
    end

    always_ff @(posedge animationCLOCK) begin
        if (reset) begin
            en_q       <= '0;
            cooldown_q <= '0;
            reqPrev_q  <= 1'b0;
            laneEnd_q  <= '0;
            dropped_q  <= 1'b0;
            count_q    <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                pos_q[i]    <= '0;
                y_q[i]      <= '0;
                scoreL_q[i] <= '0;
                gap_q[i]    <= '0;
            end
        end else begin
            en_q       <= en_d;
            cooldown_q <= cooldown_d;
            reqPrev_q  <= bus.spawnReq;
            laneEnd_q  <= laneEnd_d;
            dropped_q  <= dropped_d;
            count_q    <= count_d;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                pos_q[i]    <= pos_d[i];
                y_q[i]      <= y_d[i];
                scoreL_q[i] <= scoreL_d[i];
                gap_q[i]    <= gap_d[i];
            end
        end
    end

    logic [10*NUM_LANES-1:0] laneX_w, downY_w, upSkipY_w;
    logic [NUM_LANES-1:0]    downVis_w, upVis_w;

    always_comb begin
        laneX_w   = '0;
        downY_w   = '0;
        upSkipY_w = '0;
        downVis_w = '0;
        upVis_w   = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            laneX_w[10*i +: 10]   = 10'(pos_q[i] / 20'(SCALE));
            downY_w[10*i +: 10]   = y_q[i] + (gap_q[i] >> 1);
            upSkipY_w[10*i +: 10] = 10'(UP_IMG) - (y_q[i] - (gap_q[i] >> 1));
            if (scoreL_q[i] >= 10'(DOUBLE_MIN_SCORE)) begin
                downVis_w[i] = en_q[i];
                upVis_w[i]   = en_q[i];
            end else begin
                downVis_w[i] = en_q[i] & (y_q[i] < 10'(SCREEN_MID));
                upVis_w[i]   = en_q[i] & (y_q[i] >= 10'(SCREEN_MID));
            end
        end
    end

    assign bus.laneX        = laneX_w;
    assign bus.downY        = downY_w;
    assign bus.upSkipY      = upSkipY_w;
    assign bus.downVisible  = downVis_w;
    assign bus.upVisible    = upVis_w;
    assign bus.laneEndPulse = laneEnd_q;
    assign bus.endOfMapPipe = |laneEnd_q;
    assign bus.spawnDropped = dropped_q;
    assign bus.activeCount  = count_q;
endmodule

// File: tb/tb_pipe_lane_scheduler.sv
// Bench for pipe_lane_scheduler: closed-form lane model (spawn tick, speed,
// expiry tick) compared every cycle, plus directed literal checks.
module tb_pipe_lane_scheduler;
    localparam int L  = 3;
    localparam int P0 = 65000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_lane_scheduler_if #(.NUM_LANES(L)) bus ();
    pipe_lane_scheduler #(.NUM_LANES(L)) dut (
        .animationCLOCK(clk),
        .reset         (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each lane is described by when it spawned and its parameters
    int         tnow = 0;
    bit [L-1:0] m_act, m_pulse;
    bit         m_drop, m_reqPrev, m_ta_valid;
    int         m_ta;
    int         m_t0 [L], m_spd [L], m_texp [L], m_y [L], m_sc [L], m_gap [L];

    function automatic int gap_of(input int s);
        int r;
        if (s < 10) return 0;
        r = (s - 10) * 20;
        return (r > 25) ? 150 : 175 - r;
    endfunction

    task automatic model_step(input bit r, input bit req, input int py, input int sc);
        int free;
        tnow++;
        if (r) begin
            m_act = '0; m_pulse = '0; m_drop = 0; m_reqPrev = 0; m_ta_valid = 0;
            for (int i = 0; i < L; i++) begin
                m_y[i] = 0; m_sc[i] = 0; m_gap[i] = 0;
            end
        end else begin
            free = -1;
            for (int i = 0; i < L; i++) if (!m_act[i] && free < 0) free = i;
            m_pulse = '0;
            for (int i = 0; i < L; i++) begin
                if (m_act[i] && tnow == m_texp[i]) begin
                    m_act[i] = 0; m_pulse[i] = 1;
                end
            end
            m_drop = 0;
            if (req && !m_reqPrev) begin
                if (m_ta_valid && (tnow - m_ta) <= 40) m_drop = 1;
                else if (free < 0) m_drop = 1;
                else begin
                    m_act[free]  = 1;
                    m_t0[free]   = tnow;
                    m_y[free]    = py;
                    m_sc[free]   = sc;
                    m_gap[free]  = gap_of(sc);
                    m_spd[free]  = (sc + 1) * 35 + 220;
                    m_texp[free] = tnow + P0 / m_spd[free] + 1;
                    m_ta = tnow; m_ta_valid = 1;
                end
            end
            m_reqPrev = req;
        end
    endtask

    task automatic compare_all();
        int ex, edv, euv;
        edv = 0; euv = 0;
        for (int i = 0; i < L; i++) begin
            ex = m_act[i] ? (P0 - m_spd[i] * (tnow - m_t0[i])) / 100 : 0;
            chk($sformatf("laneX[%0d]", i), int'(bus.laneX[10*i +: 10]), ex);
            chk($sformatf("downY[%0d]", i), int'(bus.downY[10*i +: 10]), (m_y[i] + m_gap[i] / 2) & 1023);
            chk($sformatf("upSkipY[%0d]", i), int'(bus.upSkipY[10*i +: 10]), (402 - (m_y[i] - m_gap[i] / 2)) & 1023);
            if (m_act[i]) begin
                if (m_sc[i] >= 10) begin
                    edv |= (1 << i); euv |= (1 << i);
                end else if (m_y[i] < 240) edv |= (1 << i);
                else euv |= (1 << i);
            end
        end
        chk("downVisible", int'(bus.downVisible), edv);
        chk("upVisible", int'(bus.upVisible), euv);
        chk("laneEndPulse", int'(bus.laneEndPulse), int'(m_pulse));
        chk("endOfMapPipe", int'(bus.endOfMapPipe), int'(|m_pulse));
        chk("spawnDropped", int'(bus.spawnDropped), int'(m_drop));
        chk("activeCount", int'(bus.activeCount), $countones(m_act));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(rst, bus.spawnReq, int'(bus.pointY), int'(bus.score));
            #1;
            compare_all();
        end
    end

    function automatic int lane(input logic [10*L-1:0] v, input int i);
        return int'(v[10*i +: 10]);
    endfunction

    task automatic spawn_pulse(input int s, input int y);
        bus.score    = 10'(s);
        bus.pointY   = 10'(y);
        bus.spawnReq = 1'b1;
        @(negedge clk);
        bus.spawnReq = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.spawnReq = 1'b0;
        bus.pointY   = '0;
        bus.score    = '0;
        repeat (3) @(negedge clk);
        chk("rst activeCount", int'(bus.activeCount), 0);
        chk("rst visibility", int'({bus.downVisible, bus.upVisible}), 0);
        chk("rst upSkipY0", lane(bus.upSkipY, 0), 402);
        rst = 1'b0;

        // Single lane at score 0: speed 255, expiry 255 ticks after spawn
        spawn_pulse(0, 100);
        chk("A laneX0 spawn", lane(bus.laneX, 0), 650);
        chk("A downVis0", int'(bus.downVisible[0]), 1);
        chk("A upVis0", int'(bus.upVisible[0]), 0);
        chk("A activeCount", int'(bus.activeCount), 1);
        @(negedge clk);
        chk("A laneX0 step", lane(bus.laneX, 0), 647);
        repeat (253) @(negedge clk);
        chk("A pulse early", int'(bus.laneEndPulse), 0);
        @(negedge clk);
        chk("A laneEndPulse", int'(bus.laneEndPulse), 1);
        chk("A endOfMapPipe", int'(bus.endOfMapPipe), 1);
        chk("A activeCount end", int'(bus.activeCount), 0);

        // Gap and cooldown
        do_reset();
        spawn_pulse(11, 240);
        chk("B downY0", lane(bus.downY, 0), 317);
        chk("B upSkipY0", lane(bus.upSkipY, 0), 239);
        chk("B vis0", int'({bus.downVisible[0], bus.upVisible[0]}), 3);
        repeat (9) @(negedge clk);
        spawn_pulse(0, 100);
        chk("B cooldown drop", int'(bus.spawnDropped), 1);
        chk("B count after drop", int'(bus.activeCount), 1);
        repeat (30) @(negedge clk);
        spawn_pulse(10, 240);
        chk("B tick41 count", int'(bus.activeCount), 2);
        chk("B laneX1", lane(bus.laneX, 1), 650);
        chk("B gap175 downY1", lane(bus.downY, 1), 327);
        repeat (40) @(negedge clk);
        spawn_pulse(12, 240);
        chk("B gap150 downY2", lane(bus.downY, 2), 315);
        do_reset();
        spawn_pulse(30, 240);
        chk("B gap150 downY0", lane(bus.downY, 0), 315);
        chk("B gap150 upSkipY0", lane(bus.upSkipY, 0), 237);

        // Full lanes, drop when full, drop on the expiry tick, then reuse of lane 0
        do_reset();
        spawn_pulse(0, 100);
        repeat (49) @(negedge clk);
        spawn_pulse(0, 300);
        chk("C upVis1", int'(bus.upVisible[1]), 1);
        repeat (49) @(negedge clk);
        spawn_pulse(0, 200);
        chk("C full count", int'(bus.activeCount), 3);
        repeat (49) @(negedge clk);
        spawn_pulse(0, 100);
        chk("C full drop", int'(bus.spawnDropped), 1);
        repeat (104) @(negedge clk);
        spawn_pulse(5, 120);
        chk("C simul drop", int'(bus.spawnDropped), 1);
        chk("C simul pulse", int'(bus.laneEndPulse), 1);
        @(negedge clk);
        spawn_pulse(5, 120);
        chk("C reuse lane0 laneX", lane(bus.laneX, 0), 650);
        chk("C reuse count", int'(bus.activeCount), 3);

        // Mid-flight reset clears cooldown too
        rst = 1'b1;
        @(negedge clk);
        chk("D rst vis", int'({bus.downVisible, bus.upVisible}), 0);
        chk("D rst count", int'(bus.activeCount), 0);
        rst = 1'b0;
        spawn_pulse(0, 100);
        chk("D spawn after rst", int'(bus.activeCount), 1);

        // Randomised traffic, model-checked every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) bus.spawnReq = ~bus.spawnReq;
            bus.score  = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                      : 10'($urandom_range(0, 40));
            bus.pointY = 10'($urandom_range(75, 477));
        end
        @(negedge clk);
        rst = 1'b0;
        bus.spawnReq = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
